// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way write-back cache.
// Widths are functions so each instance derives them from its own parameters.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    function automatic int index_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_width, input int num_sets);
        return addr_width - $clog2(num_sets);
    endfunction

    function automatic int way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_age.sv
// Per-set LRU age tracking: victim selection for the addressed set and
// age update on every access to that set.
module cache_lru_age
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [index_w(NUM_SETS)-1:0]  set_idx,
    input  logic [NUM_WAYS-1:0]           valid_mask,
    output logic [way_w(NUM_WAYS)-1:0]    victim,
    input  logic                          upd_en,
    input  logic [way_w(NUM_WAYS)-1:0]    upd_way
);

    localparam int WAY_W = way_w(NUM_WAYS);

    logic [NUM_WAYS-1:0][WAY_W-1:0] ages [NUM_SETS];
    logic [WAY_W-1:0]               max_age;

    // Ages start as the way index, so they stay a permutation of 0..NUM_WAYS-1.
    always_comb begin
        victim  = '0;
        max_age = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (ages[set_idx][w] > max_age) begin
                max_age = ages[set_idx][w];
                victim  = WAY_W'(w);
            end
        end
        for (int unsigned w = NUM_WAYS; w > 0; w--) begin
            if (!valid_mask[w-1]) victim = WAY_W'(w - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    ages[s][w] <= WAY_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == upd_way)
                    ages[set_idx][w] <= '0;
                else if (ages[set_idx][w] < ages[set_idx][upd_way])
                    ages[set_idx][w] <= ages[set_idx][w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache, one word per line,
// with a single outstanding request and a simple req/ack memory port.
module cache_nway_wb
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 11,
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  resp_valid,
    output logic                  hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int INDEX_W = index_w(NUM_SETS);
    localparam int TAG_W   = tag_w(ADDR_WIDTH, NUM_SETS);
    localparam int WAY_W   = way_w(NUM_WAYS);

    state_t                             state;
    logic [ADDR_WIDTH-1:0]              req_addr;
    logic                               req_write;
    logic [DATA_WIDTH-1:0]              req_wdata;
    logic [WAY_W-1:0]                   victim_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]  dirty;
    logic [TAG_W-1:0]                   tag_arr  [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0]              data_arr [NUM_SETS][NUM_WAYS];

    logic [INDEX_W-1:0]    req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit_any;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic                  lru_upd;
    logic [WAY_W-1:0]      lru_way;
    logic                  line_we;
    logic [WAY_W-1:0]      line_way;
    logic [DATA_WIDTH-1:0] line_wdata;

    assign req_idx = req_addr[INDEX_W-1:0];
    assign req_tag = req_addr[ADDR_WIDTH-1:INDEX_W];

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign lru_upd = (state == LOOKUP && hit_any) || (state == REFILL && mem_ack);
    assign lru_way = (state == REFILL) ? victim_q : hit_way;

    cache_lru_age #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .set_idx    (req_idx),
        .valid_mask (valid[req_idx]),
        .victim     (victim),
        .upd_en     (lru_upd),
        .upd_way    (lru_way)
    );

    always_comb begin
        line_we    = 1'b0;
        line_way   = hit_way;
        line_wdata = req_wdata;
        if (state == LOOKUP && hit_any && req_write) begin
            line_we = 1'b1;
        end else if (state == REFILL && mem_ack) begin
            line_we    = 1'b1;
            line_way   = victim_q;
            line_wdata = req_write ? req_wdata : mem_rdata;
        end
    end

    // Tag/data storage has no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_arr[req_idx][line_way] <= line_wdata;
            tag_arr[req_idx][line_way]  <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            read_data  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_addr   <= '0;
            req_write  <= 1'b0;
            req_wdata  <= '0;
            victim_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read || write) begin
                        req_addr  <= addr;
                        req_write <= write && !read;
                        req_wdata <= write_data;
                        ready     <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    victim_q <= victim;
                    if (hit_any) begin
                        if (req_write) begin
                            dirty[req_idx][hit_way] <= 1'b1;
                            read_data               <= req_wdata;
                        end else begin
                            read_data <= data_arr[req_idx][hit_way];
                        end
                        resp_valid <= 1'b1;
                        hit        <= 1'b1;
                        state      <= RESPOND;
                    end else if (valid[req_idx][victim] && dirty[req_idx][victim]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {tag_arr[req_idx][victim], req_idx};
                        mem_wdata <= data_arr[req_idx][victim];
                        state     <= WRITEBACK;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= req_addr;
                        state    <= REFILL;
                    end
                end
                WRITEBACK: begin
                    // mem_req stays high straight into the refill of the request address.
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= req_addr;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        mem_req                  <= 1'b0;
                        valid[req_idx][victim_q] <= 1'b1;
                        dirty[req_idx][victim_q] <= req_write;
                        read_data                <= line_wdata;
                        resp_valid               <= 1'b1;
                        hit                      <= 1'b0;
                        state                    <= RESPOND;
                    end
                end
                RESPOND: begin
                    resp_valid <= 1'b0;
                    hit        <= 1'b0;
                    ready      <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Bench for cache_nway_wb: scoreboard of expected responses, memory model
// returning addr ^ 0x7FF three cycles after a request, and a memory-traffic log.
module tb_cache_nway_wb;

    localparam int AW = 11;
    localparam int DW = 11;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] ed;
        logic          eh;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          hit;
    } exp_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          ready;
    logic [DW-1:0] read_data;
    logic          resp_valid;
    logic          hit;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t     exp_q [$];
    mem_txn_t mem_log [$];

    logic          obs_valid;
    logic [DW-1:0] obs_data;
    logic          obs_hit;
    int            obs_lat;

    cache_nway_wb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WAYS   (4),
        .NUM_SETS   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .read       (read),
        .write      (write),
        .write_data (write_data),
        .ready      (ready),
        .read_data  (read_data),
        .resp_valid (resp_valid),
        .hit        (hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mv(input logic [AW-1:0] a);
        return a ^ 11'h7FF;
    endfunction

    // Memory model: acks on the third cycle mem_req is seen, logs the transaction.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req) begin
                cnt++;
                if (cnt == 3) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mv(mem_addr);
                    mem_log.push_back('{mem_we, mem_addr, mem_wdata});
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic do_reset();
        rst   = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_log.delete();
        exp_q.delete();
    endtask

    // Drives one request, pushes its expected response, captures the observed one.
    task automatic issue(input req_t r);
        int n;
        exp_q.push_back('{r.ed, r.eh});
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        addr       = r.a;
        read       = r.rd;
        write      = r.wr;
        write_data = r.wd;
        @(negedge clk);
        read    = 1'b0;
        write   = 1'b0;
        obs_lat = 1;
        while (resp_valid !== 1'b1 && obs_lat < 100) begin
            @(negedge clk);
            obs_lat++;
        end
        obs_valid = (resp_valid === 1'b1);
        obs_data  = read_data;
        obs_hit   = hit;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        issue('{1'b1, 1'b0, 11'h155, 11'h000, mv(11'h155), 1'b0});
        e = exp_q.pop_front();
        n_checks++;
        if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
            n_fail++;
            $display("FAIL reset_pre: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                     obs_valid, obs_data, obs_hit, e.data, e.hit);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready, resp_valid, hit, mem_req, mem_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: {ready,resp_valid,hit,mem_req,mem_we}=%b, expected 10000",
                     {ready, resp_valid, hit, mem_req, mem_we});
        end
        n_checks++;
        if (read_data !== '0) begin
            n_fail++;
            $display("FAIL reset_read_data: got %h, expected 000", read_data);
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: mem_addr=%h mem_wdata=%h, expected 000 000", mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue('{1'b1, 1'b0, 11'h155, 11'h000, mv(11'h155), 1'b0});
        e = exp_q.pop_front();
        n_checks++;
        if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
            n_fail++;
            $display("FAIL reset_invalidates: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                     obs_valid, obs_data, obs_hit, e.data, e.hit);
        end
    endtask

    task automatic test_cold_hit();
        exp_t e;
        do_reset();
        issue('{1'b1, 1'b0, 11'h123, 11'h000, 11'h6DC, 1'b0});
        e = exp_q.pop_front();
        n_checks++;
        if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
            n_fail++;
            $display("FAIL cold_read: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                     obs_valid, obs_data, obs_hit, e.data, e.hit);
        end
        n_checks++;
        if (mem_log.size() != 1 || mem_log[0].we !== 1'b0 || mem_log[0].addr !== 11'h123) begin
            n_fail++;
            $display("FAIL cold_refill: log size=%0d first=%h, expected one refill at 123",
                     mem_log.size(), (mem_log.size() > 0) ? mem_log[0] : '0);
        end
        issue('{1'b1, 1'b0, 11'h123, 11'h000, 11'h6DC, 1'b1});
        e = exp_q.pop_front();
        n_checks++;
        if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
            n_fail++;
            $display("FAIL hit_read: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                     obs_valid, obs_data, obs_hit, e.data, e.hit);
        end
        n_checks++;
        if (obs_lat != 2 || mem_log.size() != 1) begin
            n_fail++;
            $display("FAIL hit_latency: latency=%0d mem txns=%0d, expected 2 and 1", obs_lat, mem_log.size());
        end
    endtask

    task automatic test_lru_evict();
        exp_t          e;
        int            n_wb;
        logic [AW-1:0] at [8] = '{11'h003, 11'h00B, 11'h013, 11'h01B, 11'h003, 11'h023, 11'h003, 11'h00B};
        logic          ht [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue('{1'b1, 1'b0, at[i], 11'h000, mv(at[i]), ht[i]});
            e = exp_q.pop_front();
            n_checks++;
            if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
                n_fail++;
                $display("FAIL lru[%0d] addr=%h: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                         i, at[i], obs_valid, obs_data, obs_hit, e.data, e.hit);
            end
        end
        n_wb = 0;
        foreach (mem_log[k]) if (mem_log[k].we === 1'b1) n_wb++;
        n_checks++;
        if (n_wb != 0 || mem_log.size() != 6) begin
            n_fail++;
            $display("FAIL lru_traffic: writebacks=%0d txns=%0d, expected 0 and 6", n_wb, mem_log.size());
        end
    endtask

    task automatic test_writeback();
        exp_t e;
        req_t t [7];
        t = '{'{1'b0, 1'b1, 11'h015, 11'h0AA, 11'h0AA, 1'b0},
              '{1'b1, 1'b0, 11'h01D, 11'h000, 11'h7E2, 1'b0},
              '{1'b1, 1'b0, 11'h025, 11'h000, 11'h7DA, 1'b0},
              '{1'b1, 1'b0, 11'h02D, 11'h000, 11'h7D2, 1'b0},
              '{1'b1, 1'b0, 11'h035, 11'h000, 11'h7CA, 1'b0},
              '{1'b0, 1'b1, 11'h01D, 11'h055, 11'h055, 1'b1},
              '{1'b1, 1'b0, 11'h01D, 11'h000, 11'h055, 1'b1}};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
                n_fail++;
                $display("FAIL wb[%0d] addr=%h: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                         i, t[i].a, obs_valid, obs_data, obs_hit, e.data, e.hit);
            end
        end
        n_checks++;
        if (mem_log.size() != 6) begin
            n_fail++;
            $display("FAIL wb_count: txns=%0d, expected 6", mem_log.size());
        end else begin
            n_checks++;
            if (mem_log[4] !== {1'b1, 11'h015, 11'h0AA}) begin
                n_fail++;
                $display("FAIL wb_txn: got we=%b addr=%h wdata=%h, expected we=1 addr=015 wdata=0AA",
                         mem_log[4].we, mem_log[4].addr, mem_log[4].wdata);
            end
            n_checks++;
            if ({mem_log[5].we, mem_log[5].addr} !== {1'b0, 11'h035}) begin
                n_fail++;
                $display("FAIL wb_refill: got we=%b addr=%h, expected we=0 addr=035",
                         mem_log[5].we, mem_log[5].addr);
            end
        end
    endtask

    task automatic test_reset_refill();
        exp_t e;
        int   n;
        logic seen_resp;
        do_reset();
        addr = 11'h200;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'h200) begin
            n_fail++;
            $display("FAIL refill_start: mem_req=%b mem_we=%b mem_addr=%h, expected 1 0 200",
                     mem_req, mem_we, mem_addr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL async_abort: mem_req=%b ready=%b, expected 0 1", mem_req, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen_resp = 1'b1;
        end
        n_checks++;
        if (seen_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_resp: resp_valid seen=%b, expected 0", seen_resp);
        end
        issue('{1'b1, 1'b0, 11'h200, 11'h000, 11'h5FF, 1'b0});
        e = exp_q.pop_front();
        n_checks++;
        if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
            n_fail++;
            $display("FAIL abort_then_miss: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                     obs_valid, obs_data, obs_hit, e.data, e.hit);
        end
    endtask

    task automatic test_read_write_both();
        exp_t e;
        int   n_wb;
        req_t t [8];
        t = '{'{1'b1, 1'b0, 11'h123, 11'h000, 11'h6DC, 1'b0},
              '{1'b1, 1'b1, 11'h123, 11'h111, 11'h6DC, 1'b1},
              '{1'b1, 1'b0, 11'h123, 11'h000, 11'h6DC, 1'b1},
              '{1'b1, 1'b0, 11'h00B, 11'h000, mv(11'h00B), 1'b0},
              '{1'b1, 1'b0, 11'h013, 11'h000, mv(11'h013), 1'b0},
              '{1'b1, 1'b0, 11'h01B, 11'h000, mv(11'h01B), 1'b0},
              '{1'b1, 1'b0, 11'h02B, 11'h000, mv(11'h02B), 1'b0},
              '{1'b1, 1'b0, 11'h123, 11'h000, 11'h6DC, 1'b0}};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (!obs_valid || obs_data !== e.data || obs_hit !== e.hit) begin
                n_fail++;
                $display("FAIL rw_both[%0d] addr=%h: valid=%b data=%h hit=%b, expected data=%h hit=%b",
                         i, t[i].a, obs_valid, obs_data, obs_hit, e.data, e.hit);
            end
        end
        n_wb = 0;
        foreach (mem_log[k]) if (mem_log[k].we === 1'b1) n_wb++;
        n_checks++;
        if (n_wb != 0 || mem_log.size() != 6) begin
            n_fail++;
            $display("FAIL rw_both_clean: writebacks=%0d txns=%0d, expected 0 and 6", n_wb, mem_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_cold_hit();
        test_lru_evict();
        test_writeback();
        test_reset_refill();
        test_read_write_both();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
